// File: rtl/mem_fifo_unpacker.sv
// mem_fifo_unpacker
// Read-side stage behind a non-FWFT memory-interface FIFO. Pops one wide word at a time
// and serialises it into NUM_CHUNKS narrow chunks on a valid/ready stream.
//
// Build option: define UNPACK_MSB_FIRST_EN to emit the most significant chunk first;
// otherwise the least significant chunk is emitted first.
//
// Ports:
//   clk         clock, all state on rising edge
//   reset       asynchronous, active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_pop
//   fifo_pop    FIFO pop request (combinational)
//   out_data    current chunk
//   out_valid   out_data valid
//   out_ready   downstream accepts chunk when out_valid && out_ready
//   out_last    high with the final chunk of a word
//   words_done  count of fully emitted words, wraps
module mem_fifo_unpacker #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  words_done
);

  // DATA_WIDTH must be an integer multiple of OUT_WIDTH with at least two chunks.
  localparam int unsigned NUM_CHUNKS = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_CHUNKS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StEmit
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_WIDTH-1:0]    words_done_q, words_done_d;

  // The current chunk always sits at the output end of the shift register, so the
  // output mux is a fixed slice and each accept just shifts the next chunk into place.
`ifdef UNPACK_MSB_FIRST_EN
  assign out_data = shift_q[DATA_WIDTH-1 -: OUT_WIDTH];
`else
  assign out_data = shift_q[OUT_WIDTH-1:0];
`endif

  assign out_valid  = (state_q == StEmit);
  assign out_last   = out_valid && (idx_q == LAST_IDX);
  assign words_done = words_done_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    words_done_d = words_done_q;
    fifo_pop     = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StWait;
        end
      end
      // Non-FWFT FIFO: the popped word is on fifo_data in this cycle.
      StWait: begin
        shift_d = fifo_data;
        idx_d   = '0;
        state_d = StEmit;
      end
      StEmit: begin
        if (out_ready) begin
          if (out_last) begin
            words_done_d = words_done_q + CNT_WIDTH'(1);
            // Pop the next word in the last-accept cycle to keep the gap to one bubble.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = StWait;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
`ifdef UNPACK_MSB_FIRST_EN
            shift_d = shift_q << OUT_WIDTH;
`else
            shift_d = shift_q >> OUT_WIDTH;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // State is already cleared during reset, but the pop must not leak combinationally.
    if (reset) begin
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      shift_q      <= '0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      words_done_q <= words_done_d;
    end
  end

endmodule

// File: tb/tb_mem_fifo_unpacker.sv
// Testbench for mem_fifo_unpacker: directed steps followed by a randomized phase, all
// checked against a queue-based model of the FIFO and of the expected chunk stream.
module tb_mem_fifo_unpacker;

  localparam int unsigned DW = 64;
  localparam int unsigned OW = 16;
  localparam int unsigned NC = DW / OW;
  localparam int unsigned CW = 3;  // small counter so the random phase exercises wrap

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] words_done;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } chunk_t;

  logic [DW-1:0] fifo_q[$];
  chunk_t        exp_q[$];

  int total = 0;
  int bad = 0;
  int words_exp = 0;
  int pop_age = -1;
  int cyc = 0;
  int pop_cyc = -1;
  int first_v = -1;
  int last_acc = -1;
  int acc_cnt = 0;
  int coinc = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always #5 clk = ~clk;

  mem_fifo_unpacker #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .words_done(words_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_chunks(input logic [DW-1:0] w);
    for (int i = 0; i < NC; i++) begin
      chunk_t c;
      int     s;
`ifdef UNPACK_MSB_FIRST_EN
      s = NC - 1 - i;
`else
      s = i;
`endif
      c.data = OW'(w >> (s * OW));
      c.last = (i == NC - 1);
      exp_q.push_back(c);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
    add_chunks(w);
  endtask

  task automatic clear_stats();
    pop_cyc = -1; first_v = -1; last_acc = -1; acc_cnt = 0; coinc = 0;
  endtask

  // One clock: sample and check at the falling edge, then model the FIFO read after
  // the rising edge. Callers change inputs after this returns.
  task automatic cycle();
    logic   pop_seen;
    logic   exp_pop;
    chunk_t e;
    @(negedge clk);
    cyc++;
    if (pop_age >= 0) pop_age++;

    chk("words_done", 64'(words_done), 64'(words_exp % (1 << CW)));
    if (pop_age == 1) chk("bubble_after_pop", 64'(out_valid), 0);
    if (pop_age == 2) chk("first_chunk_latency", 64'(out_valid), 1);
    if (pop_age >= 2) pop_age = -1;

    // Pop allowed only from idle, or on the last-chunk accept; never in the wait cycle.
    if (pop_age == 1) exp_pop = 1'b0;
    else if (out_valid) exp_pop = !fifo_empty && out_last && out_ready;
    else exp_pop = !fifo_empty;
    chk("fifo_pop", 64'(fifo_pop), 64'(exp_pop));

    if (prev_stall) begin
      chk("stall_valid", 64'(out_valid), 1);
      chk("stall_data", 64'(out_data), 64'(prev_data));
      chk("stall_last", 64'(out_last), 64'(prev_last));
    end

    if (out_valid) begin
      if (first_v < 0) first_v = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'(out_valid), 0);
      end else begin
        e = exp_q[0];
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_last", 64'(out_last), 64'(e.last));
        if (out_ready) begin
          void'(exp_q.pop_front());
          acc_cnt++;
          last_acc = cyc;
          if (e.last) words_exp++;
        end
      end
    end else begin
      chk("last_without_valid", 64'(out_last), 0);
    end

    if (fifo_pop && out_valid && out_last) coinc++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    pop_seen   = fifo_pop;
    if (pop_seen) begin
      pop_age = 0;
      pop_cyc = cyc;
    end

    @(posedge clk);
    #1;
    if (pop_seen && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_until_drained(input int max);
    for (int k = 0; k < max; k++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    chk("drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    reset      = 1'b1;
    fifo_empty = 1'b1;
    out_ready  = 1'b0;
    fifo_data  = '0;

    // Reset values, and no pop while reset is high even with data available.
    #2;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_last", 64'(out_last), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_words_done", 64'(words_done), 0);
    push(64'h1111_2222_3333_4444);
    #1;
    chk("rst_no_pop", 64'(fifo_pop), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word, ready high: chunks at pop+2 .. pop+5.
    out_ready = 1'b1;
    clear_stats();
    run_until_drained(20);
    chk("w1_first_at_pop_plus2", 64'(first_v - pop_cyc), 2);
    chk("w1_last_at_pop_plus5", 64'(last_acc - pop_cyc), 5);
    chk("w1_chunks", 64'(acc_cnt), 4);
    cycle();
    chk("w1_words_done", 64'(words_done), 1);

    // Two words back-to-back: one bubble, 8 chunks over 9 cycles.
    clear_stats();
    push(64'hAAAA_BBBB_CCCC_DDDD);
    push(64'h0123_4567_89AB_CDEF);
    run_until_drained(30);
    chk("two_word_chunks", 64'(acc_cnt), 8);
    chk("two_word_span", 64'(last_acc - first_v + 1), 9);
    chk("pop_with_last", 64'(coinc), 1);
    cycle();
    chk("two_word_words_done", 64'(words_done), 3);

    // Stall five cycles on chunk 1 with another word waiting in the FIFO.
    push(64'h1111_2222_3333_4444);
    for (int k = 0; k < 20 && exp_q.size() > 3; k++) cycle();
    chk("reach_chunk1", 64'(exp_q.size()), 3);
    push(64'h5555_6666_7777_8888);
    out_ready = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    run_until_drained(30);

    // Empty FIFO throughout: no pop, no valid.
    repeat (20) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    // Asynchronous reset while chunk 2 is on the output.
    out_ready = 1'b1;
    push(64'hDEAD_BEEF_CAFE_F00D);
    for (int k = 0; k < 20 && exp_q.size() > 2; k++) cycle();
    chk("reach_chunk2", 64'(exp_q.size()), 2);
    push(64'h0F0F_1E1E_2D2D_3C3C);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 0);
    chk("async_rst_pop", 64'(fifo_pop), 0);
    chk("async_rst_words_done", 64'(words_done), 0);
    chk("async_rst_last", 64'(out_last), 0);
    exp_q.delete();
    foreach (fifo_q[i]) add_chunks(fifo_q[i]);
    words_exp  = 0;
    prev_stall = 1'b0;
    pop_age    = -1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_stats();
    run_until_drained(20);
    chk("post_rst_chunks", 64'(acc_cnt), 4);

    // Randomized traffic and backpressure.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) push({$urandom, $urandom});
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    run_until_drained(200);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
